// File: rtl/instr_seq_ctrl_pkg.sv
// Shared definitions for the accumulator CPU sequencer: opcodes, fetch
// strobe codes and the sequencer state encoding.
package cpu_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_HLT = 3'b111;

  localparam logic [1:0] FETCH_NONE = 2'b00;
  localparam logic [1:0] FETCH_B1   = 2'b01;
  localparam logic [1:0] FETCH_B2   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_F1,
    ST_F2,
    ST_DEC,
    ST_RD,
    ST_WR,
    ST_HALT,
    ST_ERR
  } state_t;

  // The four ALU opcodes occupy the lower half of the opcode space.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/instr_seq_ctrl_if.sv
// Handshake/strobe bundle between the sequencer (master) and the
// memory port / instruction register / PC / ALU side (slave).
interface instr_seq_ctrl_if;

  logic       start_i;
  logic [2:0] ins_i;
  logic       mem_ready_i;
  logic [1:0] fetch_o;
  logic       mem_rd_o;
  logic       mem_wr_o;
  logic       addr_sel_o;
  logic       pc_inc_o;
  logic       pc_load_o;
  logic       alu_en_o;
  logic       acc_we_o;
  logic       busy_o;
  logic       halted_o;
  logic       err_o;

  modport master (
    input  start_i, ins_i, mem_ready_i,
    output fetch_o, mem_rd_o, mem_wr_o, addr_sel_o, pc_inc_o, pc_load_o,
           alu_en_o, acc_we_o, busy_o, halted_o, err_o
  );

  modport slave (
    output start_i, ins_i, mem_ready_i,
    input  fetch_o, mem_rd_o, mem_wr_o, addr_sel_o, pc_inc_o, pc_load_o,
           alu_en_o, acc_we_o, busy_o, halted_o, err_o
  );

endinterface

// File: rtl/instr_seq_ctrl_mem_wait_timer.sv
// Memory wait watchdog: counts cycles spent waiting for mem_ready and flags
// the cycle in which the MEM_TIMEOUT-th consecutive wait cycle occurs.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic tick_i,
  output logic expired_o
);

  localparam logic [TO_W-1:0] LAST = TO_W'(MEM_TIMEOUT - 1);

  logic [TO_W-1:0] count_q, count_d;

  assign expired_o = tick_i && (count_q == LAST);

  // Clear on every state change; otherwise count wait cycles, saturating.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (tick_i && (count_q != LAST)) begin
      count_d = count_q + TO_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_seq_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Optional memory wait timeout (ERR state) is built when MEM_TIMEOUT_EN is
// defined; otherwise memory waits are unbounded and err is tied low.
module instr_seq_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  instr_seq_ctrl_if.master bus
);

  state_t     state_q, state_d;
  logic       alu_op_q, alu_op_d;
  logic       timeout;
  logic [1:0] fetch;
  logic       mem_rd, mem_wr, addr_sel, pc_inc, pc_load, alu_en, acc_we;

  // State and latched opcode class; reset abandons any pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      alu_op_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic wait_tick, wait_clear;

  assign wait_tick  = ((state_q == ST_F1) || (state_q == ST_F2) ||
                       (state_q == ST_RD) || (state_q == ST_WR)) && !bus.mem_ready_i;
  assign wait_clear = (state_d != state_q);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_mem_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (wait_clear),
    .tick_i   (wait_tick),
    .expired_o(timeout)
  );
`else
  logic unused_cfg;
  assign unused_cfg = (MEM_TIMEOUT > (1 << TO_W));
  assign timeout    = 1'b0;
`endif

  // Next state and strobes; fetch/pc_inc/acc_we fire only in the ready cycle.
  always_comb begin
    state_d  = state_q;
    alu_op_d = alu_op_q;
    fetch    = FETCH_NONE;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    addr_sel = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    alu_en   = 1'b0;
    acc_we   = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.start_i) state_d = ST_F1;
      end
      ST_F1: begin
        mem_rd = 1'b1;
        if (bus.mem_ready_i) begin
          fetch   = FETCH_B1;
          pc_inc  = 1'b1;
          state_d = ST_F2;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_F2: begin
        mem_rd = 1'b1;
        if (bus.mem_ready_i) begin
          fetch   = FETCH_B2;
          pc_inc  = 1'b1;
          state_d = ST_DEC;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_DEC: begin
        alu_op_d = is_alu_op(bus.ins_i);
        case (bus.ins_i)
          OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_LDA: state_d = ST_RD;
          OP_STA: state_d = ST_WR;
          OP_JMP: begin
            pc_load = 1'b1;
            state_d = ST_F1;
          end
          OP_HLT:  state_d = ST_HALT;
          default: state_d = ST_HALT;
        endcase
      end
      ST_RD: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        if (bus.mem_ready_i) begin
          acc_we  = 1'b1;
          alu_en  = alu_op_q;
          state_d = ST_F1;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_WR: begin
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
        if (bus.mem_ready_i) begin
          state_d = ST_F1;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.fetch_o    = fetch;
  assign bus.mem_rd_o   = mem_rd;
  assign bus.mem_wr_o   = mem_wr;
  assign bus.addr_sel_o = addr_sel;
  assign bus.pc_inc_o   = pc_inc;
  assign bus.pc_load_o  = pc_load;
  assign bus.alu_en_o   = alu_en;
  assign bus.acc_we_o   = acc_we;
  assign bus.busy_o     = (state_q == ST_F1) || (state_q == ST_F2) || (state_q == ST_DEC) ||
                          (state_q == ST_RD) || (state_q == ST_WR);
  assign bus.halted_o   = (state_q == ST_HALT);
`ifdef MEM_TIMEOUT_EN
  assign bus.err_o      = (state_q == ST_ERR);
`else
  assign bus.err_o      = 1'b0;
`endif

endmodule
